store_buffer: RTL and testbench

- Retirement-side consumer of the ROB store-permission interface; holds executed stores from MEM until the ROB commits them, then drains them in order to the data cache.
- Stores enter speculatively from MEM and become COMMITTED when the ROB presents sb_store_permission with their rob id.
- Also provides store-to-load forwarding to MEM and discards uncommitted stores on an exception flush.

---
 rtl/store_buffer.sv | 145 ++++++++++++++
 tb/tb_store_buffer.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/store_buffer.sv
// Store buffer: holds executed stores until the ROB commits them, drains committed
// stores in order to the data cache and forwards buffered store data to loads.
module store_buffer #(
  parameter int N               = 4,
  parameter int WORD_SIZE       = 32,
  parameter int ROB_ENTRY_WIDTH = 3
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       mem_store_valid,
  input  logic [WORD_SIZE-1:0]       mem_store_addr,
  input  logic [WORD_SIZE-1:0]       mem_store_data,
  input  logic                       mem_store_byte,
  input  logic [ROB_ENTRY_WIDTH-1:0] mem_store_rob_id,
  output logic                       full,
  output logic                       empty,
  input  logic                       sb_store_permission,
  input  logic [ROB_ENTRY_WIDTH-1:0] sb_rob_id,
  input  logic                       flush,
  input  logic [WORD_SIZE-1:0]       ld_addr,
  input  logic                       ld_byte,
  output logic                       fwd_hit,
  output logic [WORD_SIZE-1:0]       fwd_data,
  output logic                       fwd_stall,
  output logic                       dc_req,
  output logic [WORD_SIZE-1:0]       dc_addr,
  output logic [WORD_SIZE-1:0]       dc_data,
  output logic                       dc_byte,
  input  logic                       dc_ack
);
  localparam int PTR_W = (N > 1) ? $clog2(N) : 1;
  localparam int CNT_W = $clog2(N) + 1;

  typedef enum logic [1:0] {FREE, PENDING, COMMITTED} ent_state_t;

  ent_state_t                 st_q   [N];
  ent_state_t                 st_d   [N];
  logic [WORD_SIZE-1:0]       addr_q [N];
  logic [WORD_SIZE-1:0]       data_q [N];
  logic                       byte_q [N];
  logic [ROB_ENTRY_WIDTH-1:0] rob_q  [N];

  logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d, n_commit;
  logic             alloc, drain, alloc_commit;
  logic [PTR_W-1:0] idx;

  assign full  = (count_q == CNT_W'(N));
  assign empty = (count_q == '0);

  // Drain port: head entry is offered only once committed; zero otherwise
  assign dc_req  = (st_q[head_q] == COMMITTED);
  assign dc_addr = dc_req ? addr_q[head_q] : '0;
  assign dc_data = dc_req ? data_q[head_q] : '0;
  assign dc_byte = dc_req & byte_q[head_q];

  assign alloc        = mem_store_valid && !full && !flush;
  assign drain        = dc_req && dc_ack;
  assign alloc_commit = sb_store_permission && (mem_store_rob_id == sb_rob_id);

  // Next-state: commit, then drain, then flush (which also cancels allocation)
  always_comb begin
    n_commit = '0;
    for (int i = 0; i < N; i++) begin
      st_d[i] = st_q[i];
      if (sb_store_permission && st_q[i] == PENDING && rob_q[i] == sb_rob_id)
        st_d[i] = COMMITTED;
    end
    if (drain)
      st_d[head_q] = FREE;
    head_d = drain ? head_q + PTR_W'(1) : head_q;
    if (flush) begin
      for (int i = 0; i < N; i++) begin
        if (st_d[i] == PENDING)
          st_d[i] = FREE;
        if (st_d[i] == COMMITTED)
          n_commit = n_commit + CNT_W'(1);
      end
      tail_d  = head_d + PTR_W'(n_commit);
      count_d = n_commit;
    end else begin
      tail_d  = alloc ? tail_q + PTR_W'(1) : tail_q;
      count_d = count_q + CNT_W'(alloc) - CNT_W'(drain);
      if (alloc)
        st_d[tail_q] = alloc_commit ? COMMITTED : PENDING;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < N; i++)
        st_q[i] <= FREE;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      for (int i = 0; i < N; i++)
        st_q[i] <= st_d[i];
    end
  end

  // Payload needs no reset: it is only observed through valid entry state
  always_ff @(posedge clk) begin
    if (alloc) begin
      addr_q[tail_q] <= mem_store_addr;
      data_q[tail_q] <= mem_store_byte ? {{(WORD_SIZE-8){1'b0}}, mem_store_data[7:0]}
                                       : mem_store_data;
      byte_q[tail_q] <= mem_store_byte;
      rob_q[tail_q]  <= mem_store_rob_id;
    end
  end

  // Forwarding: walk oldest to youngest so the youngest overlapping entry wins
  always_comb begin
    fwd_hit   = 1'b0;
    fwd_stall = 1'b0;
    fwd_data  = '0;
    idx       = '0;
    for (int i = 0; i < N; i++) begin
      idx = head_q + PTR_W'(i);
      if (CNT_W'(i) < count_q && st_q[idx] != FREE &&
          addr_q[idx][WORD_SIZE-1:2] == ld_addr[WORD_SIZE-1:2]) begin
        if (byte_q[idx] && ld_byte) begin
          if (addr_q[idx][1:0] == ld_addr[1:0]) begin
            fwd_hit   = 1'b1;
            fwd_stall = 1'b0;
            fwd_data  = {{(WORD_SIZE-8){1'b0}}, data_q[idx][7:0]};
          end
        end else if (byte_q[idx] == ld_byte) begin
          fwd_hit   = 1'b1;
          fwd_stall = 1'b0;
          fwd_data  = data_q[idx];
        end else begin
          fwd_hit   = 1'b0;
          fwd_stall = 1'b1;
          fwd_data  = '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_store_buffer.sv
// Bench for store_buffer: directed scenarios plus randomized traffic checked
// against a queue-based model of the buffer contents.
module tb_store_buffer;
  localparam int N = 4;

  logic        clk, rst;
  logic        mem_store_valid, mem_store_byte;
  logic [31:0] mem_store_addr, mem_store_data;
  logic [2:0]  mem_store_rob_id, sb_rob_id;
  logic        full, empty, sb_store_permission, flush;
  logic [31:0] ld_addr, fwd_data, dc_addr, dc_data;
  logic        ld_byte, fwd_hit, fwd_stall, dc_req, dc_byte, dc_ack;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic        byt;
    logic [2:0]  rob;
    logic        com;
  } ent_t;

  ent_t mq[$];

  store_buffer #(.N(N), .WORD_SIZE(32), .ROB_ENTRY_WIDTH(3)) dut (
    .clk(clk), .rst(rst),
    .mem_store_valid(mem_store_valid), .mem_store_addr(mem_store_addr),
    .mem_store_data(mem_store_data), .mem_store_byte(mem_store_byte),
    .mem_store_rob_id(mem_store_rob_id), .full(full), .empty(empty),
    .sb_store_permission(sb_store_permission), .sb_rob_id(sb_rob_id),
    .flush(flush), .ld_addr(ld_addr), .ld_byte(ld_byte),
    .fwd_hit(fwd_hit), .fwd_data(fwd_data), .fwd_stall(fwd_stall),
    .dc_req(dc_req), .dc_addr(dc_addr), .dc_data(dc_data), .dc_byte(dc_byte),
    .dc_ack(dc_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle();
    mem_store_valid = 0; mem_store_addr = 0; mem_store_data = 0; mem_store_byte = 0;
    mem_store_rob_id = 0; sb_store_permission = 0; sb_rob_id = 0; flush = 0;
    ld_addr = 0; ld_byte = 0; dc_ack = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    #2;
    rst = 1'b0;
    tick();
  endtask

  task automatic push(input logic [31:0] a, input logic [31:0] d, input logic b, input logic [2:0] id);
    mem_store_valid = 1; mem_store_addr = a; mem_store_data = d;
    mem_store_byte = b; mem_store_rob_id = id;
    tick();
    mem_store_valid = 0;
  endtask

  task automatic test_reset();
    idle();
    rst = 1'b1;
    #2;
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty: got %0b want 1", empty); end
    checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full: got %0b want 0", full); end
    checks++; if (dc_req !== 1'b0) begin errors++; $display("FAIL reset_dc_req: got %0b want 0", dc_req); end
    checks++; if (dc_addr !== 32'h0) begin errors++; $display("FAIL reset_dc_addr: got %h want 0", dc_addr); end
    checks++; if (dc_data !== 32'h0) begin errors++; $display("FAIL reset_dc_data: got %h want 0", dc_data); end
    checks++; if (fwd_hit !== 1'b0 || fwd_stall !== 1'b0 || fwd_data !== 32'h0) begin
      errors++; $display("FAIL reset_fwd: got hit=%0b stall=%0b data=%h want 0/0/0", fwd_hit, fwd_stall, fwd_data); end
    tick();
    rst = 1'b0;
    tick();
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL reset_release_empty: got %0b want 1", empty); end
  endtask

  task automatic test_single_drain();
    do_reset();
    push(32'h100, 32'hDEADBEEF, 1'b0, 3'd2);
    sb_store_permission = 1; sb_rob_id = 3'd2; dc_ack = 1;
    #1;
    checks++; if (dc_req !== 1'b0) begin errors++; $display("FAIL drain_pending_req: got %0b want 0", dc_req); end
    tick();
    sb_store_permission = 0;
    checks++; if (dc_req !== 1'b1) begin errors++; $display("FAIL drain_req: got %0b want 1", dc_req); end
    checks++; if (dc_addr !== 32'h100) begin errors++; $display("FAIL drain_addr: got %h want 100", dc_addr); end
    checks++; if (dc_data !== 32'hDEADBEEF) begin errors++; $display("FAIL drain_data: got %h want deadbeef", dc_data); end
    checks++; if (dc_byte !== 1'b0) begin errors++; $display("FAIL drain_byte: got %0b want 0", dc_byte); end
    tick();
    dc_ack = 0;
    checks++; if (empty !== 1'b1 || dc_req !== 1'b0) begin
      errors++; $display("FAIL drain_done: got empty=%0b req=%0b want 1/0", empty, dc_req); end
  endtask

  task automatic test_full_fwd();
    do_reset();
    for (int i = 0; i < 4; i++)
      push(32'h100 + 32'(4 * i), 32'hA000_0000 + 32'(i), 1'b0, 3'(i));
    checks++; if (full !== 1'b1) begin errors++; $display("FAIL full_set: got %0b want 1", full); end
    push(32'h110, 32'h55, 1'b0, 3'd4);
    checks++; if (full !== 1'b1 || empty !== 1'b0) begin
      errors++; $display("FAIL full_hold: got full=%0b empty=%0b want 1/0", full, empty); end
    ld_addr = 32'h108; ld_byte = 0;
    #1;
    checks++; if (fwd_hit !== 1'b1 || fwd_data !== 32'hA000_0002 || fwd_stall !== 1'b0) begin
      errors++; $display("FAIL fwd_third: got hit=%0b data=%h stall=%0b want 1/a0000002/0", fwd_hit, fwd_data, fwd_stall); end
    ld_addr = 32'h110;
    #1;
    checks++; if (fwd_hit !== 1'b0 || fwd_stall !== 1'b0) begin
      errors++; $display("FAIL fwd_ignored: got hit=%0b stall=%0b want 0/0", fwd_hit, fwd_stall); end
  endtask

  task automatic test_overlap();
    do_reset();
    push(32'h200, 32'd1, 1'b0, 3'd0);
    push(32'h200, 32'd2, 1'b0, 3'd1);
    ld_addr = 32'h200; ld_byte = 0;
    #1;
    checks++; if (fwd_hit !== 1'b1 || fwd_data !== 32'd2) begin
      errors++; $display("FAIL fwd_youngest: got hit=%0b data=%h want 1/2", fwd_hit, fwd_data); end
    push(32'h300, 32'h12345678, 1'b0, 3'd2);
    ld_addr = 32'h301; ld_byte = 1;
    #1;
    checks++; if (fwd_stall !== 1'b1 || fwd_hit !== 1'b0) begin
      errors++; $display("FAIL fwd_partial: got stall=%0b hit=%0b want 1/0", fwd_stall, fwd_hit); end
    push(32'h401, 32'h0000CDAB, 1'b1, 3'd3);
    ld_addr = 32'h401; ld_byte = 1;
    #1;
    checks++; if (fwd_hit !== 1'b1 || fwd_data !== 32'h0000_00AB) begin
      errors++; $display("FAIL fwd_byte: got hit=%0b data=%h want 1/000000ab", fwd_hit, fwd_data); end
    ld_addr = 32'h402;
    #1;
    checks++; if (fwd_hit !== 1'b0 || fwd_stall !== 1'b0) begin
      errors++; $display("FAIL fwd_byte_skip: got hit=%0b stall=%0b want 0/0", fwd_hit, fwd_stall); end
    ld_addr = 32'h400; ld_byte = 0;
    #1;
    checks++; if (fwd_stall !== 1'b1 || fwd_hit !== 1'b0) begin
      errors++; $display("FAIL fwd_word_over_byte: got stall=%0b hit=%0b want 1/0", fwd_stall, fwd_hit); end
  endtask

  task automatic test_flush();
    do_reset();
    push(32'h100, 32'h11, 1'b0, 3'd0);
    push(32'h104, 32'h22, 1'b0, 3'd1);
    push(32'h108, 32'h33, 1'b0, 3'd2);
    sb_store_permission = 1; sb_rob_id = 3'd0;
    tick();
    sb_store_permission = 0;
    flush = 1;
    mem_store_valid = 1; mem_store_addr = 32'h600; mem_store_data = 32'h66; mem_store_rob_id = 3'd3;
    tick();
    flush = 0; mem_store_valid = 0;
    checks++; if (dc_req !== 1'b1 || dc_addr !== 32'h100 || empty !== 1'b0) begin
      errors++; $display("FAIL flush_keep: got req=%0b addr=%h empty=%0b want 1/100/0", dc_req, dc_addr, empty); end
    ld_addr = 32'h104; ld_byte = 0;
    #1;
    checks++; if (fwd_hit !== 1'b0) begin errors++; $display("FAIL flush_drop: got hit=%0b want 0", fwd_hit); end
    ld_addr = 32'h600;
    #1;
    checks++; if (fwd_hit !== 1'b0) begin errors++; $display("FAIL flush_no_alloc: got hit=%0b want 0", fwd_hit); end
    push(32'h500, 32'h77, 1'b0, 3'd3);
    ld_addr = 32'h500;
    #1;
    checks++; if (fwd_hit !== 1'b1 || fwd_data !== 32'h77 || dc_addr !== 32'h100) begin
      errors++; $display("FAIL flush_tail: got hit=%0b data=%h dc_addr=%h want 1/77/100", fwd_hit, fwd_data, dc_addr); end
    dc_ack = 1;
    tick();
    dc_ack = 0;
    checks++; if (dc_req !== 1'b0 || empty !== 1'b0) begin
      errors++; $display("FAIL flush_after_drain: got req=%0b empty=%0b want 0/0", dc_req, empty); end
  endtask

  task automatic test_hold();
    do_reset();
    push(32'h340, 32'hCAFEF00D, 1'b0, 3'd5);
    sb_store_permission = 1; sb_rob_id = 3'd5;
    tick();
    sb_store_permission = 0;
    for (int c = 0; c < 3; c++) begin
      checks++; if (dc_req !== 1'b1 || dc_addr !== 32'h340 || dc_data !== 32'hCAFEF00D) begin
        errors++; $display("FAIL hold_cycle%0d: got req=%0b addr=%h data=%h want 1/340/cafef00d", c, dc_req, dc_addr, dc_data); end
      tick();
    end
    dc_ack = 1;
    tick();
    dc_ack = 0;
    checks++; if (empty !== 1'b1 || dc_req !== 1'b0) begin
      errors++; $display("FAIL hold_release: got empty=%0b req=%0b want 1/0", empty, dc_req); end
  endtask

  task automatic test_async_reset();
    do_reset();
    push(32'h700, 32'h99, 1'b0, 3'd1);
    sb_store_permission = 1; sb_rob_id = 3'd1;
    tick();
    sb_store_permission = 0;
    ld_addr = 32'h700; ld_byte = 0;
    #1;
    checks++; if (dc_req !== 1'b1 || fwd_hit !== 1'b1) begin
      errors++; $display("FAIL arst_pre: got req=%0b hit=%0b want 1/1", dc_req, fwd_hit); end
    #1;
    rst = 1'b1;
    #1;
    checks++; if (dc_req !== 1'b0 || dc_addr !== 32'h0 || dc_data !== 32'h0 || dc_byte !== 1'b0) begin
      errors++; $display("FAIL arst_dc: got req=%0b addr=%h data=%h byte=%0b want zeros", dc_req, dc_addr, dc_data, dc_byte); end
    checks++; if (empty !== 1'b1 || full !== 1'b0 || fwd_hit !== 1'b0 || fwd_stall !== 1'b0 || fwd_data !== 32'h0) begin
      errors++; $display("FAIL arst_status: got empty=%0b full=%0b hit=%0b stall=%0b data=%h want 1/0/0/0/0",
                         empty, full, fwd_hit, fwd_stall, fwd_data); end
    #1;
    rst = 1'b0;
    tick();
  endtask

  task automatic test_random();
    logic        v, byt, fl, ack, perm, will_alloc, lb, drn;
    logic [31:0] a, d, la, e_data;
    logic [2:0]  next_id, pid;
    logic        e_hit, e_stall, e_req;
    int          pidx;
    ent_t        e;
    ent_t        keep[$];
    do_reset();
    mq.delete();
    next_id = 3'd0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      v   = ($urandom_range(0, 3) != 0);
      byt = 1'($urandom % 2);
      a   = 32'h100 + 32'(4 * $urandom_range(0, 3));
      if (byt) a = a + 32'($urandom_range(0, 3));
      d   = $urandom;
      fl  = ($urandom_range(0, 15) == 0);
      ack = 1'($urandom % 2);
      will_alloc = v && (mq.size() < N) && !fl;
      pidx = -1;
      for (int i = 0; i < mq.size(); i++)
        if (!mq[i].com) begin pidx = i; break; end
      perm = 0;
      pid  = next_id + 3'd3;
      if (pidx >= 0 && ($urandom % 2) == 1) begin perm = 1; pid = mq[pidx].rob; end
      else if (pidx < 0 && will_alloc && ($urandom % 2) == 1) begin perm = 1; pid = next_id; end
      else if (($urandom % 4) == 0) perm = 1;
      lb = 1'($urandom % 2);
      la = 32'h100 + 32'($urandom_range(0, 15));
      if (!lb) la[1:0] = 2'b00;

      mem_store_valid = v; mem_store_addr = a; mem_store_data = d; mem_store_byte = byt;
      mem_store_rob_id = next_id; sb_store_permission = perm; sb_rob_id = pid;
      flush = fl; dc_ack = ack; ld_addr = la; ld_byte = lb;

      @(negedge clk);
      e_req = (mq.size() > 0) && mq[0].com;
      e_hit = 0; e_stall = 0; e_data = 0;
      for (int i = mq.size() - 1; i >= 0; i--) begin
        if (mq[i].addr[31:2] == la[31:2]) begin
          if (mq[i].byt && lb && mq[i].addr[1:0] != la[1:0]) continue;
          if (mq[i].byt == lb) begin
            e_hit = 1;
            e_data = lb ? {24'h0, mq[i].data[7:0]} : mq[i].data;
          end else e_stall = 1;
          break;
        end
      end
      checks++; if (full !== (mq.size() == N) || empty !== (mq.size() == 0)) begin
        errors++; $display("FAIL rnd_status cyc%0d: got full=%0b empty=%0b model size %0d", cyc, full, empty, mq.size()); end
      checks++; if (dc_req !== e_req) begin
        errors++; $display("FAIL rnd_dc_req cyc%0d: got %0b want %0b", cyc, dc_req, e_req); end
      if (e_req) begin
        checks++; if (dc_addr !== mq[0].addr || dc_byte !== mq[0].byt ||
                      (mq[0].byt ? (dc_data[7:0] !== mq[0].data[7:0]) : (dc_data !== mq[0].data))) begin
          errors++; $display("FAIL rnd_dc_payload cyc%0d: got %h/%h/%0b want %h/%h/%0b", cyc,
                             dc_addr, dc_data, dc_byte, mq[0].addr, mq[0].data, mq[0].byt); end
      end
      checks++; if (fwd_hit !== e_hit || fwd_stall !== e_stall) begin
        errors++; $display("FAIL rnd_fwd cyc%0d: got hit=%0b stall=%0b want %0b/%0b", cyc, fwd_hit, fwd_stall, e_hit, e_stall); end
      if (e_hit) begin
        checks++; if (fwd_data !== e_data) begin
          errors++; $display("FAIL rnd_fwd_data cyc%0d: got %h want %h", cyc, fwd_data, e_data); end
      end

      @(posedge clk);
      drn = (mq.size() > 0) && mq[0].com && ack;
      for (int i = 0; i < mq.size(); i++)
        if (perm && !mq[i].com && mq[i].rob == pid) begin
          e = mq[i]; e.com = 1'b1; mq[i] = e;
        end
      if (drn) void'(mq.pop_front());
      if (fl) begin
        keep.delete();
        for (int i = 0; i < mq.size(); i++)
          if (mq[i].com) keep.push_back(mq[i]);
        mq = keep;
      end else if (will_alloc) begin
        e.addr = a; e.data = d; e.byt = byt; e.rob = next_id; e.com = perm && (pid == next_id);
        mq.push_back(e);
      end
      if (will_alloc) next_id = next_id + 3'd1;
      #1;
    end
    idle();
  endtask

  initial begin
    rst = 1'b0;
    idle();
    test_reset();
    test_single_drain();
    test_full_fwd();
    test_overlap();
    test_flush();
    test_hold();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
